// File: rtl/pcie_serdes_pkg.sv
// Shared types and helpers for the ECP5 PCIe SERDES reset/power-up sequencer.
// Holds the sequencer state encoding, lane-count legality and counter sizing.
package pcie_serdes_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN    = 3'd0,
    ST_DUAL_RST = 3'd1,
    ST_WAIT_PLL = 3'd2,
    ST_TX_RST   = 3'd3,
    ST_WAIT_CDR = 3'd4,
    ST_RX_RST   = 3'd5,
    ST_READY    = 3'd6
  } seq_state_e;

  localparam int RETRY_W = 4;

  function automatic bit lanes_legal(input int n);
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

  // Width that can hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pcie_serdes_rst_seq_if.sv
// Sequencer <-> SERDES/PCS/PCIe-core signal bundle. Every signal is a level;
// there is no valid/ready handshake: values are sampled each sys_clk_125 edge.
interface pcie_serdes_rst_seq_if #(parameter int NUM_LANES = 1);
  logic                 tx_pll_lol;
  logic [NUM_LANES-1:0] rx_cdr_lol;
  logic [NUM_LANES-1:0] rx_los;
  logic                 serdes_pdb;
  logic                 tx_pwrup_c;
  logic                 serdes_rst_dual_c;
  logic                 tx_serdes_rst_c;
  logic [NUM_LANES-1:0] rx_serdes_rst_c;
  logic [NUM_LANES-1:0] rx_pcs_rst_c;
  logic                 pcsclkdiv_rst;
  logic                 sli_rst;
  logic [NUM_LANES-1:0] lane_ready;
  logic [2:0]           seq_state;
  logic [3:0]           retry_cnt;

  modport master (
    input  tx_pll_lol, rx_cdr_lol, rx_los,
    output serdes_pdb, tx_pwrup_c, serdes_rst_dual_c, tx_serdes_rst_c,
           rx_serdes_rst_c, rx_pcs_rst_c, pcsclkdiv_rst, sli_rst,
           lane_ready, seq_state, retry_cnt
  );

  modport slave (
    output tx_pll_lol, rx_cdr_lol, rx_los,
    input  serdes_pdb, tx_pwrup_c, serdes_rst_dual_c, tx_serdes_rst_c,
           rx_serdes_rst_c, rx_pcs_rst_c, pcsclkdiv_rst, sli_rst,
           lane_ready, seq_state, retry_cnt
  );
endinterface

// File: rtl/pcie_lane_lock_det.sv
// Per-lane CDR lock detector: counts consecutive good cycles to declare lock,
// then counts consecutive bad cycles to debounce loss of lock.
module pcie_lane_lock_det
  import pcie_serdes_pkg::*;
#(
  parameter int RX_LOCK_CYC  = 12500,
  parameter int LOL_DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic flush,
  input  logic los,
  input  logic cdr_lol,
  output logic lock_nxt,
  output logic locked
);

  localparam int CW = cnt_width(max3(RX_LOCK_CYC, LOL_DEBOUNCE, 1));

  logic [CW-1:0] cnt_q, cnt_d, cnt_raw, cnt_inc;
  logic          locked_q, locked_d, locked_raw, good;

  // One counter serves both phases: good-run length while unlocked,
  // bad-run length while locked.
  always_comb begin
    good       = !los && !cdr_lol;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    cnt_raw    = '0;
    locked_raw = 1'b0;
    if (enable) begin
      if (!locked_q) begin
        cnt_raw = good ? cnt_inc : '0;
        if (cnt_raw >= CW'(RX_LOCK_CYC)) begin
          locked_raw = 1'b1;
          cnt_raw    = '0;
        end
      end else begin
        cnt_raw    = good ? '0 : cnt_inc;
        locked_raw = 1'b1;
        if (cnt_raw >= CW'(LOL_DEBOUNCE)) begin
          locked_raw = 1'b0;
          cnt_raw    = '0;
        end
      end
    end
    cnt_d    = flush ? '0 : cnt_raw;
    locked_d = locked_raw && !flush;
    lock_nxt = locked_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/pcie_serdes_rst_seq.sv
// Timed reset/power-up sequencer for the ECP5 PCIe SERDES/PCS (x1/x2/x4).
// All outputs are flops loaded from the next-state decode, aligned with seq_state.
module pcie_serdes_rst_seq
  import pcie_serdes_pkg::*;
#(
  parameter int NUM_LANES    = 1,
  parameter int POWER_CYC    = 2500,
  parameter int TX_RST_CYC   = 250,
  parameter int PLL_LOCK_CYC = 12500,
  parameter int RX_LOCK_CYC  = 12500,
  parameter int LOL_DEBOUNCE = 16,
  parameter int TIMEOUT_CYC  = 1250000
) (
  input  logic sys_clk_125,
  input  logic rst_n,
  input  logic force_reset,
  pcie_serdes_rst_seq_if.master serdes
);

  localparam int TIMER_W = cnt_width(max3(POWER_CYC, TX_RST_CYC, TIMEOUT_CYC));
  localparam int PLL_W   = cnt_width(PLL_LOCK_CYC);
  localparam int LOL_W   = cnt_width(LOL_DEBOUNCE);

  generate
    if (!lanes_legal(NUM_LANES)) begin : g_bad_lanes
      $error("pcie_serdes_rst_seq: NUM_LANES must be 1, 2 or 4");
    end
  endgenerate

  seq_state_e           state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [PLL_W-1:0]     pll_cnt_q, pll_cnt_d, pll_run;
  logic [LOL_W-1:0]     lol_cnt_q, lol_cnt_d, lol_run;
  logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
  logic                 pwr_on_q, pwr_on_d;
  logic                 dual_q, dual_d;
  logic                 txrst_q, txrst_d;
  logic                 rxs_q, rxs_d;
  logic                 sli_q, sli_d;
  logic                 entry, lane_en, lane_flush;
  logic [NUM_LANES-1:0] lock_nxt, lane_locked;

  assign lane_en = (state_q == ST_WAIT_CDR) || (state_q == ST_READY);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pcie_lane_lock_det #(
      .RX_LOCK_CYC (RX_LOCK_CYC),
      .LOL_DEBOUNCE(LOL_DEBOUNCE)
    ) u_det (
      .clk     (sys_clk_125),
      .rst_n   (rst_n),
      .enable  (lane_en),
      .flush   (lane_flush),
      .los     (serdes.rx_los[i]),
      .cdr_lol (serdes.rx_cdr_lol[i]),
      .lock_nxt(lock_nxt[i]),
      .locked  (lane_locked[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
    retry_d   = retry_q;
    pll_run   = '0;
    lol_run   = '0;
    if (state_q == ST_WAIT_PLL && !serdes.tx_pll_lol)
      pll_run = (pll_cnt_q == '1) ? pll_cnt_q : pll_cnt_q + PLL_W'(1);
    if (state_q == ST_READY && serdes.tx_pll_lol)
      lol_run = (lol_cnt_q == '1) ? lol_cnt_q : lol_cnt_q + LOL_W'(1);

    case (state_q)
      ST_PWRDN:
        if (timer_q == TIMER_W'(POWER_CYC)) state_d = ST_DUAL_RST;
      ST_DUAL_RST:
        if (timer_q == TIMER_W'(TX_RST_CYC)) state_d = ST_WAIT_PLL;
      ST_WAIT_PLL:
        if (pll_run == PLL_W'(PLL_LOCK_CYC)) begin
          state_d = ST_TX_RST;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYC)) begin
          state_d = ST_DUAL_RST;
          retry_d = retry_inc;
        end
      ST_TX_RST:
        if (timer_q == TIMER_W'(TX_RST_CYC)) state_d = ST_WAIT_CDR;
      ST_WAIT_CDR:
        if (&lock_nxt) begin
          state_d = ST_READY;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYC)) begin
          // Lane 0 alone is enough for a down-trained link.
          if (lock_nxt[0]) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_RX_RST;
            retry_d = retry_inc;
          end
        end
      ST_RX_RST:
        if (timer_q == TIMER_W'(TX_RST_CYC)) state_d = ST_WAIT_CDR;
      ST_READY:
        if (lol_run >= LOL_W'(LOL_DEBOUNCE)) state_d = ST_DUAL_RST;
        else if (!lock_nxt[0])               state_d = ST_RX_RST;
      default:
        state_d = ST_PWRDN;
    endcase

    if (force_reset) begin
      state_d = ST_DUAL_RST;
      retry_d = retry_q;
    end

    // force_reset restarts the timer even when already in DUAL_RST.
    entry     = (state_d != state_q) || force_reset;
    timer_d   = entry ? TIMER_W'(1)
                      : ((timer_q == '1) ? timer_q : timer_q + TIMER_W'(1));
    pll_cnt_d = entry ? '0 : pll_run;
    lol_cnt_d = entry ? '0 : lol_run;

    lane_flush = !((state_d == ST_WAIT_CDR) || (state_d == ST_READY));
    pwr_on_d   = pwr_on_q || (state_d != ST_PWRDN);
    dual_d     = (state_d == ST_PWRDN) || (state_d == ST_DUAL_RST);
    txrst_d    = dual_d || (state_d == ST_WAIT_PLL) || (state_d == ST_TX_RST);
    rxs_d      = txrst_d || (state_d == ST_RX_RST);
    sli_d      = (state_d != ST_READY) || dual_d || txrst_d || !pwr_on_d;
  end

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PWRDN;
      timer_q   <= TIMER_W'(1);
      pll_cnt_q <= '0;
      lol_cnt_q <= '0;
      retry_q   <= '0;
      pwr_on_q  <= 1'b0;
      dual_q    <= 1'b1;
      txrst_q   <= 1'b1;
      rxs_q     <= 1'b1;
      sli_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pll_cnt_q <= pll_cnt_d;
      lol_cnt_q <= lol_cnt_d;
      retry_q   <= retry_d;
      pwr_on_q  <= pwr_on_d;
      dual_q    <= dual_d;
      txrst_q   <= txrst_d;
      rxs_q     <= rxs_d;
      sli_q     <= sli_d;
    end
  end

  assign serdes.serdes_pdb        = pwr_on_q;
  assign serdes.tx_pwrup_c        = pwr_on_q;
  assign serdes.serdes_rst_dual_c = dual_q;
  assign serdes.tx_serdes_rst_c   = txrst_q;
  assign serdes.pcsclkdiv_rst     = txrst_q;
  assign serdes.rx_serdes_rst_c   = {NUM_LANES{rxs_q}};
  assign serdes.rx_pcs_rst_c      = ~lane_locked;
  assign serdes.lane_ready        = lane_locked;
  assign serdes.sli_rst           = sli_q;
  assign serdes.seq_state         = state_q;
  assign serdes.retry_cnt         = retry_q;

endmodule

// File: tb/tb_pcie_serdes_rst_seq.sv
// Directed bench for pcie_serdes_rst_seq (x4, shortened timing parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pcie_serdes_rst_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic force_reset;

  always #5 clk = ~clk;

  pcie_serdes_rst_seq_if #(.NUM_LANES(4)) sif ();

  pcie_serdes_rst_seq #(
    .NUM_LANES   (4),
    .POWER_CYC   (4),
    .TX_RST_CYC  (8),
    .PLL_LOCK_CYC(16),
    .RX_LOCK_CYC (16),
    .LOL_DEBOUNCE(4),
    .TIMEOUT_CYC (256)
  ) dut (
    .sys_clk_125(clk),
    .rst_n      (rst_n),
    .force_reset(force_reset),
    .serdes     (sif)
  );

  typedef struct {
    int         cyc;
    logic       lol;
    logic [3:0] cdr;
    logic [3:0] los;
    logic       frc;
    logic [2:0] st;
    logic       sli;
    logic [3:0] lr;
    logic [3:0] rt;
    logic       dual;
    logic       tx;
    logic       pdb;
    logic       rxs;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic vec_t mk(input int cyc, input logic lol, input logic [3:0] cdr,
                              input logic [3:0] los, input logic frc, input logic [2:0] st,
                              input logic sli, input logic [3:0] lr, input logic [3:0] rt,
                              input logic dual, input logic tx, input logic pdb,
                              input logic rxs);
    vec_t v;
    v.cyc = cyc; v.lol = lol; v.cdr = cdr; v.los = los; v.frc = frc;
    v.st = st; v.sli = sli; v.lr = lr; v.rt = rt;
    v.dual = dual; v.tx = tx; v.pdb = pdb; v.rxs = rxs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic lol, input logic [3:0] cdr, input logic [3:0] los,
                        input logic frc);
    sif.tx_pll_lol = lol;
    sif.rx_cdr_lol = cdr;
    sif.rx_los     = los;
    force_reset    = frc;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic sli,
                            input logic [3:0] lr, input logic [3:0] rt, input logic dual,
                            input logic tx, input logic pdb, input logic rxs);
    logic [3:0] nlr;
    logic [3:0] rxs4;
    nlr  = ~lr;
    rxs4 = {4{rxs}};
    chk({tag, ".seq_state"},         sif.seq_state,         st);
    chk({tag, ".sli_rst"},           sif.sli_rst,           sli);
    chk({tag, ".lane_ready"},        sif.lane_ready,        lr);
    chk({tag, ".rx_pcs_rst_c"},      sif.rx_pcs_rst_c,      nlr);
    chk({tag, ".retry_cnt"},         sif.retry_cnt,         rt);
    chk({tag, ".serdes_rst_dual_c"}, sif.serdes_rst_dual_c, dual);
    chk({tag, ".tx_serdes_rst_c"},   sif.tx_serdes_rst_c,   tx);
    chk({tag, ".pcsclkdiv_rst"},     sif.pcsclkdiv_rst,     tx);
    chk({tag, ".serdes_pdb"},        sif.serdes_pdb,        pdb);
    chk({tag, ".tx_pwrup_c"},        sif.tx_pwrup_c,        pdb);
    chk({tag, ".rx_serdes_rst_c"},   sif.rx_serdes_rst_c,   rxs4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 4'h0, 1'b0);
    adv(2);
    check_outs("in_reset", 3'd0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    //            cyc lol cdr   los   frc st sli lr    rt   dual tx pdb rxs
    // Bring-up with clean inputs: READY exactly 52 edges after release.
    vecs.push_back(mk(0,  0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'd0, 1, 1, 0, 1));
    vecs.push_back(mk(3,  0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 4'd0, 1, 1, 0, 1));
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 0, 1, 1, 4'h0, 4'd0, 1, 1, 1, 1));
    vecs.push_back(mk(7,  0, 4'h0, 4'h0, 0, 1, 1, 4'h0, 4'd0, 1, 1, 1, 1));
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 0, 2, 1, 4'h0, 4'd0, 0, 1, 1, 1));
    vecs.push_back(mk(16, 0, 4'h0, 4'h0, 0, 3, 1, 4'h0, 4'd0, 0, 1, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(15, 0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    // Lane 0 CDR loss: 3-cycle glitch ignored, 4 cycles forces RX_RST.
    vecs.push_back(mk(3,  0, 4'h1, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(3,  0, 4'h1, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  0, 4'h1, 4'h0, 0, 5, 1, 4'h0, 4'd0, 0, 0, 1, 1));
    vecs.push_back(mk(7,  0, 4'h0, 4'h0, 0, 5, 1, 4'h0, 4'd0, 0, 0, 1, 1));
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(15, 0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    // PLL loss in READY: 4 cycles returns to DUAL_RST, then full recovery.
    vecs.push_back(mk(3,  1, 4'h0, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(1,  1, 4'h0, 4'h0, 0, 1, 1, 4'h0, 4'd0, 1, 1, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h0, 0, 2, 1, 4'h0, 4'd0, 0, 1, 1, 1));
    vecs.push_back(mk(16, 0, 4'h0, 4'h0, 0, 3, 1, 4'h0, 4'd0, 0, 1, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(16, 0, 4'h0, 4'h0, 0, 6, 0, 4'hF, 4'd0, 0, 0, 1, 0));
    // Lane 0 LOS: RX_RST, then WAIT_CDR timeout with lane 0 unlocked -> retry.
    vecs.push_back(mk(4,  0, 4'h0, 4'h1, 0, 5, 1, 4'h0, 4'd0, 0, 0, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h1, 0, 4, 1, 4'h0, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(16, 0, 4'h0, 4'h1, 0, 4, 1, 4'hE, 4'd0, 0, 0, 1, 0));
    vecs.push_back(mk(240,0, 4'h0, 4'h1, 0, 5, 1, 4'h0, 4'd1, 0, 0, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd1, 0, 0, 1, 0));
    // force_reset in WAIT_CDR: DUAL_RST next edge, retry count kept.
    vecs.push_back(mk(1,  0, 4'h0, 4'h0, 1, 1, 1, 4'h0, 4'd1, 1, 1, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h0, 0, 2, 1, 4'h0, 4'd1, 0, 1, 1, 1));
    vecs.push_back(mk(16, 0, 4'h0, 4'h0, 0, 3, 1, 4'h0, 4'd1, 0, 1, 1, 1));
    vecs.push_back(mk(8,  0, 4'h0, 4'h0, 0, 4, 1, 4'h0, 4'd1, 0, 0, 1, 0));
    vecs.push_back(mk(16, 0, 4'h0, 4'h0, 0, 6, 0, 4'hF, 4'd1, 0, 0, 1, 0));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].lol, vecs[i].cdr, vecs[i].los, vecs[i].frc);
      adv(vecs[i].cyc);
      check_outs($sformatf("v%0d", i), vecs[i].st, vecs[i].sli, vecs[i].lr, vecs[i].rt,
                 vecs[i].dual, vecs[i].tx, vecs[i].pdb, vecs[i].rxs);
    end

    // Lane 2 never gets signal: down-trained READY after the WAIT_CDR timeout.
    do_reset();
    sif.rx_los = 4'b0100;
    adv(52);
    check_outs("dt_lock", 3'd4, 1'b1, 4'b1011, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    adv(239);
    check_outs("dt_pre", 3'd4, 1'b1, 4'b1011, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    adv(1);
    check_outs("dt_ready", 3'd6, 1'b0, 4'b1011, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sif.rx_los = 4'b0000;
    adv(15);
    check_outs("relock_pre", 3'd6, 1'b0, 4'b1011, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    adv(1);
    check_outs("relock", 3'd6, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Loss on lane 3 only drops that lane; the link stays up.
    sif.rx_los = 4'b1000;
    adv(3);
    check_outs("l3_glitch", 3'd6, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    adv(1);
    check_outs("l3_lost", 3'd6, 1'b0, 4'b0111, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sif.rx_los = 4'b0000;
    adv(16);
    check_outs("l3_relock", 3'd6, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // PLL never locks: timeout every 264 cycles, retry saturates at 15.
    do_reset();
    for (int k = 1; k <= 16; k++) exp_q.push_back((k > 15) ? 4'd15 : 4'(k));
    sif.tx_pll_lol = 1'b1;
    adv(267);
    check_outs("pll_to_pre0", 3'd2, 1'b1, 4'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_rt;
      if (k > 1) begin
        adv(263);
        chk($sformatf("pll_to_pre%0d.seq_state", k - 1), sif.seq_state, 3'd2);
      end
      adv(1);
      exp_rt = exp_q.pop_front();
      chk($sformatf("pll_to%0d.seq_state", k), sif.seq_state, 3'd1);
      chk($sformatf("pll_to%0d.retry_cnt", k), sif.retry_cnt, exp_rt);
      chk($sformatf("pll_to%0d.sli_rst", k), sif.sli_rst, 1'b1);
      chk($sformatf("pll_to%0d.serdes_rst_dual_c", k), sif.serdes_rst_dual_c, 1'b1);
    end

    // Asynchronous reset in TX_RST clears everything without a clock edge.
    sif.tx_pll_lol = 1'b0;
    adv(26);
    check_outs("pre_async", 3'd3, 1'b1, 4'h0, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_outs("async_rst", 3'd0, 1'b1, 4'h0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    adv(1);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
